// File: rtl/ram_bus_pkg.sv
// -----------------------------------------------------------------------------
// ram_bus_pkg
// Shared definitions for the CPU-side RAM port-A adapter and its load path.
//  - access size / read / write type encodings (RT_*, WT_*, RT_SIGNED bit)
//  - adapter state encoding (IDLE / RD_WAIT / RD_DONE)
//  - RAM column geometry (NUM_COL x COL_WIDTH)
//  - helper functions: alignment test, column-enable mask, store-lane replication
// -----------------------------------------------------------------------------
package ram_bus_pkg;

    localparam int NUM_COL    = 4;
    localparam int COL_WIDTH  = 8;
    localparam int DATA_WIDTH = NUM_COL * COL_WIDTH;

    // read_type[1:0] size encoding; read_type[RT_SIGNED] selects sign extension
    localparam logic [1:0] RT_NONE = 2'b00;
    localparam logic [1:0] RT_B    = 2'b01;
    localparam logic [1:0] RT_H    = 2'b10;
    localparam logic [1:0] RT_W    = 2'b11;
    localparam int         RT_SIGNED = 2;

    // write_type size encoding (same size code as reads)
    localparam logic [1:0] WT_NONE = 2'b00;
    localparam logic [1:0] WT_B    = 2'b01;
    localparam logic [1:0] WT_H    = 2'b10;
    localparam logic [1:0] WT_W    = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RD_WAIT = 2'b01,
        RD_DONE = 2'b10
    } state_e;

    // Natural alignment: halves on even bytes, words on word boundaries.
    function automatic logic size_aligned(input logic [1:0] size, input logic [1:0] offset);
        logic ok;
        case (size)
            RT_H:    ok = (offset[0] == 1'b0);
            RT_W:    ok = (offset == 2'b00);
            default: ok = 1'b1;
        endcase
        return ok;
    endfunction

    // Column write enables for a store of the given size at the given byte offset.
    function automatic logic [NUM_COL-1:0] col_mask(input logic [1:0] size, input logic [1:0] offset);
        logic [NUM_COL-1:0] m;
        case (size)
            WT_B:    m = 4'b0001 << offset;
            WT_H:    m = 4'b0011 << offset;
            WT_W:    m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // Right-aligned store data copied into every lane so the column enables
    // alone pick the destination bytes.
    function automatic logic [DATA_WIDTH-1:0] lane_replicate(input logic [1:0] size,
                                                              input logic [DATA_WIDTH-1:0] data);
        logic [DATA_WIDTH-1:0] r;
        case (size)
            WT_B:    r = {4{data[7:0]}};
            WT_H:    r = {2{data[15:0]}};
            default: r = data;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ram_bus_adapter_if.sv
// -----------------------------------------------------------------------------
// ram_bus_adapter_if
// Bundles the CPU request/response signals and the RAM port-A signals seen by
// ram_bus_adapter.
//  slave  : the adapter's view (requests and ram_dout in; responses and RAM
//           controls out)
//  master : the requester/RAM environment's view (mirror image)
// Signals:
//  addr[ADDR_WIDTH+1:0] byte address, read_type[2:0], write_type[1:0],
//  data_in[31:0], data_out[31:0], data_ready, busy, misaligned,
//  ram_we[3:0], ram_addr[ADDR_WIDTH-1:0], ram_din[31:0], ram_dout[31:0]
// -----------------------------------------------------------------------------
interface ram_bus_adapter_if #(
    parameter int ADDR_WIDTH = 12
) ();
    import ram_bus_pkg::*;

    logic [ADDR_WIDTH+1:0]   addr;
    logic [2:0]              read_type;
    logic [1:0]              write_type;
    logic [DATA_WIDTH-1:0]   data_in;
    logic [DATA_WIDTH-1:0]   data_out;
    logic                    data_ready;
    logic                    busy;
    logic                    misaligned;
    logic [NUM_COL-1:0]      ram_we;
    logic [ADDR_WIDTH-1:0]   ram_addr;
    logic [DATA_WIDTH-1:0]   ram_din;
    logic [DATA_WIDTH-1:0]   ram_dout;

    modport slave (
        input  addr, read_type, write_type, data_in, ram_dout,
        output data_out, data_ready, busy, misaligned, ram_we, ram_addr, ram_din
    );

    modport master (
        output addr, read_type, write_type, data_in, ram_dout,
        input  data_out, data_ready, busy, misaligned, ram_we, ram_addr, ram_din
    );

endinterface

// File: rtl/ram_load_extend.sv
// -----------------------------------------------------------------------------
// ram_load_extend
// Combinational load-result formatter: picks the addressed byte/half lane out
// of a 32-bit word and zero- or sign-extends it to 32 bits.
// Ports:
//  word      in  32  raw word read from memory/peripheral
//  offset    in  2   byte offset of the access within the word
//  read_type in  3   [1:0] size (none/byte/half/word), [2] sign-extend
//  value     out 32  extended result (0 for size none)
// -----------------------------------------------------------------------------
module ram_load_extend
    import ram_bus_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] word,
    input  logic [1:0]            offset,
    input  logic [2:0]            read_type,
    output logic [DATA_WIDTH-1:0] value
);

    logic [DATA_WIDTH-1:0] shifted_s;
    logic                  sign_en_s;

    // Bring the addressed lane down to bit 0; word accesses are aligned so the
    // shift is zero for them.
    assign shifted_s = word >> {offset, 3'b000};
    assign sign_en_s = read_type[RT_SIGNED];

    // Size select and sign/zero fill.
    always_comb begin
        value = 32'h0000_0000;
        case (read_type[1:0])
            RT_B:    value = {{24{sign_en_s & shifted_s[7]}},  shifted_s[7:0]};
            RT_H:    value = {{16{sign_en_s & shifted_s[15]}}, shifted_s[15:0]};
            RT_W:    value = shifted_s;
            default: value = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/ram_bus_adapter.sv
// -----------------------------------------------------------------------------
// ram_bus_adapter
// CPU-side front end of the byte-enabled dual-port RAM, port A.
//  - Stores complete in the request cycle: column enables and lane-replicated
//    data are driven combinationally.
//  - Loads present the word address, wait one cycle for the RAM's registered
//    read, then register the lane-extracted, extended result (data_ready two
//    cycles after the request).
//  - Misaligned requests are rejected with a one-cycle misaligned pulse.
// Ports:
//  clk, rst_n (async active-low)
//  bus (ram_bus_adapter_if.slave): addr, read_type, write_type, data_in,
//      data_out, data_ready, busy, misaligned, ram_we, ram_addr, ram_din, ram_dout
// -----------------------------------------------------------------------------
module ram_bus_adapter
    import ram_bus_pkg::*;
#(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    ram_bus_adapter_if.slave    bus
);

    state_e                state_r;
    state_e                state_next_s;
    logic [NUM_COL-1:0]    ram_we_s;
    logic                  load_start_s;
    logic                  capture_s;
    logic                  misalign_s;

    logic [1:0]            off_r;
    logic [2:0]            rt_r;
    logic [DATA_WIDTH-1:0] data_out_r;
    logic                  data_ready_r;
    logic                  busy_r;
    logic                  misaligned_r;
    logic [DATA_WIDTH-1:0] ext_s;

    // Lane select and extension of the word returned by the RAM, using the
    // offset and type captured when the load was accepted.
    ram_load_extend u_extend (
        .word      (bus.ram_dout),
        .offset    (off_r),
        .read_type (rt_r),
        .value     (ext_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and request decode; a store always beats a simultaneous load.
    always_comb begin
        state_next_s = state_r;
        ram_we_s     = 4'b0000;
        load_start_s = 1'b0;
        capture_s    = 1'b0;
        misalign_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.write_type != WT_NONE) begin
                    if (size_aligned(bus.write_type, bus.addr[1:0])) begin
                        ram_we_s = col_mask(bus.write_type, bus.addr[1:0]);
                    end else begin
                        misalign_s = 1'b1;
                    end
                end else if (bus.read_type[1:0] != RT_NONE) begin
                    if (size_aligned(bus.read_type[1:0], bus.addr[1:0])) begin
                        load_start_s = 1'b1;
                        state_next_s = RD_WAIT;
                    end else begin
                        misalign_s = 1'b1;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            RD_WAIT: begin
                capture_s    = 1'b1;
                state_next_s = RD_DONE;
            end
            RD_DONE: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Load context capture, result register and registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            off_r        <= 2'b00;
            rt_r         <= 3'b000;
            data_out_r   <= 32'h0000_0000;
            data_ready_r <= 1'b0;
            busy_r       <= 1'b0;
            misaligned_r <= 1'b0;
        end else begin
            busy_r       <= load_start_s;
            data_ready_r <= capture_s;
            misaligned_r <= misalign_s;
            if (load_start_s) begin
                off_r <= bus.addr[1:0];
                rt_r  <= bus.read_type;
            end
            if (capture_s) begin
                data_out_r <= ext_s;
            end
        end
    end

    // Column enables are gated by reset so nothing is written while rst_n is low.
    assign bus.ram_we     = rst_n ? ram_we_s : 4'b0000;
    assign bus.ram_addr   = bus.addr[ADDR_WIDTH+1:2];
    assign bus.ram_din    = lane_replicate(bus.write_type, bus.data_in);

    assign bus.data_out   = data_out_r;
    assign bus.data_ready = data_ready_r;
    assign bus.busy       = busy_r;
    assign bus.misaligned = misaligned_r;

endmodule
